// File: rtl/i2c_slave.sv
// I2C target: 7-bit address match, byte write to o_rx_data, byte read from i_tx_data.
// Bus inputs are 2-flop synchronized; actions occur ~3 i_clk after SCL/SDA edges; no backpressure (bus-timed).
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_req,
  output logic       o_busy,
  output logic [2:0] o_status
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  state_t     state_q, state_d;
  logic       scl_s1, scl_s2, scl_h;
  logic       sda_s1, sda_s2, sda_h;
  logic       scl_rise, scl_fall, start, stop;
  logic [3:0] cnt_q;
  logic [6:0] shift_q;
  logic [7:0] rx_byte;
  logic       rw_q, sda_oe_q, busy_q, addr_hit_q, nack_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_h  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_h  <= 1'b1;
    end else begin
      scl_s1 <= i_scl;
      scl_s2 <= scl_s1;
      scl_h  <= scl_s2;
      sda_s1 <= i_sda;
      sda_s2 <= sda_s1;
      sda_h  <= sda_s2;
    end
  end

  assign scl_rise = scl_s2 & ~scl_h;
  assign scl_fall = ~scl_s2 & scl_h;
  assign start    = scl_s2 & sda_h & ~sda_s2;
  assign stop     = scl_s2 & ~sda_h & sda_s2;
  // Byte as it stands once the current rising edge's bit is included
  assign rx_byte  = {shift_q, sda_s2};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = ADDR;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise && cnt_q == 4'd1 && rx_byte[7:1] != SLAVE_ADDR) state_d = IGNORE;
          else if (scl_fall && cnt_q == 4'd0)                          state_d = ADDR_ACK;
        end
        ADDR_ACK: if (scl_fall) state_d = rw_q ? RD_BYTE : WR_BYTE;
        WR_BYTE:  if (scl_fall && cnt_q == 4'd0) state_d = WR_ACK;
        WR_ACK:   if (scl_fall) state_d = WR_BYTE;
        RD_BYTE:  if (scl_fall && cnt_q == 4'd0) state_d = RD_ACK;
        // NACK leaves on the rising edge, so any falling edge here follows an ACK
        RD_ACK: begin
          if (scl_rise && sda_s2) state_d = IGNORE;
          else if (scl_fall)      state_d = RD_BYTE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q      <= 4'd0;
      shift_q    <= 7'd0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      addr_hit_q <= 1'b0;
      nack_q     <= 1'b0;
      o_rx_data  <= 8'h00;
      o_rx_valid <= 1'b0;
      o_tx_req   <= 1'b0;
    end else begin
      o_rx_valid <= 1'b0;
      o_tx_req   <= 1'b0;
      if (stop) begin
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (start) begin
        sda_oe_q <= 1'b0;
        cnt_q    <= 4'd8;
      end else begin
        case (state_q)
          ADDR: begin
            if (scl_rise && cnt_q != 4'd0) begin
              shift_q <= rx_byte[6:0];
              cnt_q   <= cnt_q - 4'd1;
              if (cnt_q == 4'd1) begin
                rw_q <= sda_s2;
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  addr_hit_q <= 1'b1;
                  busy_q     <= 1'b1;
                end else begin
                  busy_q <= 1'b0;
                end
              end
            end else if (scl_fall && cnt_q == 4'd0) begin
              sda_oe_q <= 1'b1;
            end
          end
          ADDR_ACK, RD_ACK: begin
            if (state_q == RD_ACK && scl_rise && sda_s2) begin
              nack_q <= 1'b1;
              busy_q <= 1'b0;
            end else if (scl_fall) begin
              if (state_q == RD_ACK || rw_q) begin
                o_tx_req <= 1'b1;
                shift_q  <= i_tx_data[6:0];
                sda_oe_q <= ~i_tx_data[7];
              end else begin
                sda_oe_q <= 1'b0;
              end
              cnt_q <= 4'd8;
            end
          end
          WR_BYTE: begin
            if (scl_rise && cnt_q != 4'd0) begin
              shift_q <= rx_byte[6:0];
              cnt_q   <= cnt_q - 4'd1;
              if (cnt_q == 4'd1) begin
                o_rx_data  <= rx_byte;
                o_rx_valid <= 1'b1;
              end
            end else if (scl_fall && cnt_q == 4'd0) begin
              sda_oe_q <= 1'b1;
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              cnt_q    <= 4'd8;
            end
          end
          RD_BYTE: begin
            if (scl_rise && cnt_q != 4'd0) begin
              cnt_q <= cnt_q - 4'd1;
            end else if (scl_fall) begin
              if (cnt_q == 4'd0) begin
                sda_oe_q <= 1'b0;
              end else begin
                sda_oe_q <= ~shift_q[6];
                shift_q  <= {shift_q[5:0], 1'b0};
              end
            end
          end
          default: begin
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  // SDA may only be pulled in states that legitimately own the bus
  always_comb begin
    o_sda_oe = sda_oe_q & ((state_q == ADDR_ACK) || (state_q == WR_ACK) || (state_q == RD_BYTE));
    o_busy   = busy_q;
    o_status = {addr_hit_q, nack_q, 1'b0};
  end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h42, 7-bit target address this block responds to.
REQ-002 i_clk  input  1  system clock; oversamples SCL/SDA; SHALL be at least 8x the SCL frequency.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_scl  input  1  bus SCL, asynchronous to i_clk.
REQ-005 i_sda  input  1  bus SDA as seen on the pad, asynchronous to i_clk.
REQ-006 o_sda_oe  output  1  1 = pull SDA low; 0 = release SDA (open-drain, external pull-up).
REQ-007 o_rx_data  output  8  last byte written by the master.
REQ-008 o_rx_valid  output  1  one-cycle pulse; o_rx_data is new.
REQ-009 i_tx_data  input  8  byte returned on a master read; sampled when o_tx_req pulses.
REQ-010 o_tx_req  output  1  one-cycle pulse; i_tx_data captured this cycle.
REQ-011 o_busy  output  1  high from an address-matched START until STOP or NACK-to-idle.
REQ-012 o_status  output  3  {addr_hit_sticky, master_nack_sticky, rx_overrun_sticky}; cleared only by reset.

Function
REQ-013 i_scl and i_sda SHALL each pass through a 2-flop synchronizer, then into a 1-flop history register; edges are detected by comparing the synchronized and history values.
REQ-014 START: synchronized SDA falls while synchronized SCL is high; STOP: SDA rises while SCL is high. Both are detected in any state.
REQ-015 States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
REQ-016 START (including a repeated START) in any state -> ADDR, bit counter = 8, o_sda_oe = 0.
REQ-017 STOP in any state -> IDLE, o_sda_oe = 0, o_busy = 0.
REQ-018 Bits are sampled MSB first on a detected SCL rising edge; o_sda_oe changes only on a detected SCL falling edge (except reset, STOP and START).
REQ-019 ADDR: after 8 rising edges, {addr[6:0], rw} is captured.
- Match: addr_hit_sticky = 1, o_busy = 1; on the next falling edge -> ADDR_ACK with o_sda_oe = 1.
- No match: -> IGNORE; o_sda_oe stays 0.
REQ-020 ADDR_ACK: on the falling edge after the ACK clock, release SDA.
- rw = 0 -> WR_BYTE.
- rw = 1 -> RD_BYTE: pulse o_tx_req, load i_tx_data into the shift register, and drive bit 7 in the same cycle (o_sda_oe = ~bit).
REQ-021 WR_BYTE: on the 8th rising edge, o_rx_data <= shifted byte and o_rx_valid pulses on the next i_clk cycle.
- If o_rx_valid pulsed and the next byte completes with no intervening reset, the block cannot tell whether the byte was consumed; rx_overrun_sticky is never set by this path (reserved).
- Next falling edge -> WR_ACK with o_sda_oe = 1.
REQ-022 WR_ACK: next falling edge -> release SDA -> WR_BYTE, counter = 8; unlimited bytes per transaction.
REQ-023 RD_BYTE: each subsequent falling edge drives the next bit (o_sda_oe = ~bit); after bit 0's clock, the next falling edge releases SDA -> RD_ACK.
REQ-024 RD_ACK: sample SDA on the rising edge.
- 0 (ACK): on the next falling edge, pulse o_tx_req, load i_tx_data, drive bit 7, -> RD_BYTE.
- 1 (NACK): master_nack_sticky = 1 -> IGNORE, SDA released.
REQ-025 IGNORE: o_sda_oe = 0; leave only on START or STOP; o_busy = 0.
REQ-026 START and STOP detected in the same cycle as an SCL edge take priority over the bit/ACK action of that edge.
REQ-027 o_sda_oe SHALL never be 1 in IDLE, ADDR, IGNORE, or while SCL is high except during ACK or read-data hold.

Reset
REQ-028 i_rst_n low asynchronously sets: state = IDLE, o_sda_oe = 0, o_rx_data = 8'h00, o_rx_valid = 0, o_tx_req = 0, o_busy = 0, o_status = 3'b000, synchronizers = 1, history = 1.
REQ-029 Reset mid-transfer SHALL release SDA immediately; after deassertion the block ignores the bus until the next START.

Verification
REQ-030 Write: START, 0x84 (addr 0x42, W), byte 0xA5, STOP -> o_sda_oe high on both ACK clocks; one o_rx_valid pulse with o_rx_data = 0xA5; o_status = 3'b100.
REQ-031 Address miss: START, 0x26 (addr 0x13), 0xFF, STOP -> o_sda_oe never asserted; no o_rx_valid; o_busy stays 0.
REQ-032 Read: i_tx_data = 0x3C, START, 0x85, master ACK, then NACK -> SDA pattern 0,0,1,1,1,1,0,0 per byte; two o_tx_req pulses; master_nack_sticky = 1; SDA released after NACK.
REQ-033 Repeated START: write 0x84 and 0x11, then START, 0x85 without STOP -> o_rx_data = 0x11; read phase begins; no spurious o_rx_valid.
REQ-034 Reset mid-read: assert i_rst_n low during bit 3 of a read byte -> o_sda_oe = 0 immediately; bus traffic ignored until a new START, after which the block responds normally.
REQ-035 Back-to-back write of 0x01, 0x02, 0x03 in one transaction -> three o_rx_valid pulses, in order, each acknowledged.
